// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - hazard/forwarding unit with multi-cycle execute ops, memory wait stalls and stall counter
module hazard_unit_mc #(
    parameter int AW     = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    Rs1D,
    input  logic [AW-1:0]    Rs2D,
    input  logic [AW-1:0]    Rs1E,
    input  logic [AW-1:0]    Rs2E,
    input  logic [AW-1:0]    RdE,
    input  logic [AW-1:0]    RdM,
    input  logic [AW-1:0]    RdW,
    input  logic             PCSrcE,
    input  logic             LoadE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             McStartE,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             McBusy,
    output logic [CNT_W-1:0] StallCount
);

    localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((MC_LAT > 1) ? MC_LAT - 2 : 0);
    localparam bit MC_MULTI = (MC_LAT > 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mc_busy_q, mc_busy_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic mem_stall, lw_stall, mc_stall;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs);
        if (RegWriteM && (RdM != '0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E);
    assign ForwardBE = fwd_sel(Rs2E);

    assign mem_stall = ~MemReadyM;
    assign lw_stall  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    // The start term is gated by reset so an op presented during reset never stalls.
    assign mc_stall  = reset && (((state_q == IDLE) && McStartE && MC_MULTI) ||
                                 ((state_q == BUSY) && (cnt_q != '0)));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (mc_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushE = lw_stall | PCSrcE;
            FlushD = PCSrcE;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_count_d = stall_count_q;
        if (!mem_stall) begin
            case (state_q)
                IDLE: if (McStartE && MC_MULTI) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
                BUSY: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                      else             state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        mc_busy_d = (state_d == BUSY);
        if (StallF && (stall_count_q != '1))
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mc_busy_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mc_busy_q     <= mc_busy_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign McBusy     = mc_busy_q;
    assign StallCount = stall_count_q;

endmodule
